// File: rtl/matmul_pkg.sv
// Shared types and default parameter-block addresses for the matmul sequencer.
package matmul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      RD_A,
      RD_B,
      ACC,
      WR_C,
      DONE
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_M_ADDR     = 0;
   localparam int DEF_N_ADDR     = 2;
   localparam int DEF_L_ADDR     = 4;
   localparam int DEF_PA_ADDR    = 12;
   localparam int DEF_PC_ADDR    = 14;
   localparam logic [2:0] FETCH_LAST = 3'd5;

endpackage

// File: rtl/matmul_addr_gen.sv
// Combinational operand/result address generation; all sums wrap mod 2**ADDR_WIDTH.
module matmul_addr_gen
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] pa,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] m,
   input  logic [DATA_WIDTH-1:0] n,
   input  logic [DATA_WIDTH-1:0] l,
   input  logic [DATA_WIDTH-1:0] i,
   input  logic [DATA_WIDTH-1:0] j,
   input  logic [DATA_WIDTH-1:0] k,
   output logic [ADDR_WIDTH-1:0] a_addr,
   output logic [ADDR_WIDTH-1:0] b_addr,
   output logic [ADDR_WIDTH-1:0] c_addr
);

   // Truncating each factor first gives the same low bits as the full-width product.
   assign a_addr = pa + ADDR_WIDTH'(i) * ADDR_WIDTH'(n) + ADDR_WIDTH'(k);
   assign b_addr = pa + ADDR_WIDTH'(m) * ADDR_WIDTH'(n)
                      + ADDR_WIDTH'(k) * ADDR_WIDTH'(l) + ADDR_WIDTH'(j);
   assign c_addr = pc + ((ADDR_WIDTH'(i) * ADDR_WIDTH'(l) + ADDR_WIDTH'(j)) << 1);

endmodule

// File: rtl/matmul_seq.sv
// Sequencer that walks data memory to compute C = A x B, one double-byte write per C element.
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int M_ADDR     = DEF_M_ADDR,
   parameter int N_ADDR     = DEF_N_ADDR,
   parameter int L_ADDR     = DEF_L_ADDR,
   parameter int PA_ADDR    = DEF_PA_ADDR,
   parameter int PC_ADDR    = DEF_PC_ADDR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_we,
   output logic [2*DATA_WIDTH-1:0] mem_w_data,
   output logic [ADDR_WIDTH-1:0]   mem_w_addr,
   output logic [ADDR_WIDTH-1:0]   mem_r_addr,
   input  logic [DATA_WIDTH-1:0]   mem_r_data
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   state_t          state;
   logic [2:0]      p;
   logic [DW-1:0]   m, n, l, i, j, k, a_reg;
   logic [DW-1:0]   i_nx, j_nx, k_nx;
   logic [AW-1:0]   pa, pc, a_addr, b_addr, c_addr;
   logic [2*DW-1:0] acc, acc_sum;
   logic            i_last, j_last, k_last;

   assign i_last  = (i == m - ONE);
   assign j_last  = (j == l - ONE);
   assign k_last  = (k == n - ONE);
   assign acc_sum = acc + ({{DW{1'b0}}, a_reg} * {{DW{1'b0}}, mem_r_data});

   // Counter values after this edge; the address generator sees these so that
   // r_addr/w_addr can be registered on the edge that enters RD_A/RD_B/WR_C.
   always_comb begin
      i_nx = i;
      j_nx = j;
      k_nx = k;
      case (state)
         FETCH: if (p == FETCH_LAST) begin
            i_nx = '0;
            j_nx = '0;
            k_nx = '0;
         end
         ACC:   k_nx = k_last ? '0 : k + ONE;
         WR_C:  if (j_last) begin
            j_nx = '0;
            i_nx = i + ONE;
         end else begin
            j_nx = j + ONE;
         end
         default: ;
      endcase
   end

   matmul_addr_gen #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) u_addr_gen (
      .pa     (pa),
      .pc     (pc),
      .m      (m),
      .n      (n),
      .l      (l),
      .i      (i_nx),
      .j      (j_nx),
      .k      (k_nx),
      .a_addr (a_addr),
      .b_addr (b_addr),
      .c_addr (c_addr)
   );

   // Read data lags r_addr by one cycle, so each state consumes what the previous one addressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         p          <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_we     <= 1'b0;
         mem_w_data <= '0;
         mem_w_addr <= '0;
         mem_r_addr <= '0;
         m          <= '0;
         n          <= '0;
         l          <= '0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         pa         <= '0;
         pc         <= '0;
         a_reg      <= '0;
         acc        <= '0;
      end else begin
         i <= i_nx;
         j <= j_nx;
         k <= k_nx;
         case (state)
            IDLE: if (start) begin
               state      <= FETCH;
               p          <= '0;
               busy       <= 1'b1;
               mem_r_addr <= AW'(M_ADDR);
            end
            FETCH: begin
               p <= p + 3'd1;
               case (p)
                  3'd0: mem_r_addr <= AW'(N_ADDR);
                  3'd1: begin m <= mem_r_data; mem_r_addr <= AW'(L_ADDR);  end
                  3'd2: begin n <= mem_r_data; mem_r_addr <= AW'(PA_ADDR); end
                  3'd3: begin l <= mem_r_data; mem_r_addr <= AW'(PC_ADDR); end
                  3'd4: pa <= AW'(mem_r_data);
                  3'd5: begin
                     pc  <= AW'(mem_r_data);
                     acc <= '0;
                     if (m == '0 || n == '0 || l == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state      <= RD_A;
                        mem_r_addr <= a_addr;
                     end
                  end
                  default: ;
               endcase
            end
            RD_A: begin
               state      <= RD_B;
               mem_r_addr <= b_addr;
            end
            RD_B: begin
               state <= ACC;
               a_reg <= mem_r_data;
            end
            ACC: begin
               acc <= acc_sum;
               if (k_last) begin
                  state      <= WR_C;
                  mem_we     <= 1'b1;
                  mem_w_addr <= c_addr;
                  mem_w_data <= acc_sum;
               end else begin
                  state      <= RD_A;
                  mem_r_addr <= a_addr;
               end
            end
            WR_C: begin
               mem_we <= 1'b0;
               acc    <= '0;
               if (i_last && j_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state      <= RD_A;
                  mem_r_addr <= a_addr;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a byte-wide registered-read memory model.
module tb_matmul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done, mem_we;
   logic [15:0] mem_w_data;
   logic [7:0]  mem_w_addr, mem_r_addr, mem_r_data;

   logic [7:0]  mem [256];
   logic        tbWe;
   logic [7:0]  tbAddr, tbData;

   int checkCount = 0;
   int failCount  = 0;
   int cycles, wes;

   matmul_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem_we     (mem_we),
      .mem_w_data (mem_w_data),
      .mem_w_addr (mem_w_addr),
      .mem_r_addr (mem_r_addr),
      .mem_r_data (mem_r_data)
   );

   always #5 clk = ~clk;

   // Memory model: DUT write has priority, bench preload port used only while the DUT is idle.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_w_addr]        <= mem_w_data[7:0];
         mem[mem_w_addr + 8'd1] <= mem_w_data[15:8];
      end else if (tbWe) begin
         mem[tbAddr] <= tbData;
      end
      mem_r_data <= mem[mem_r_addr];
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic memPoke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tbWe   = 1'b1;
      tbAddr = a;
      tbData = d;
      @(posedge clk);
      #1 tbWe = 1'b0;
   endtask

   task automatic loadDims(input int m, input int n, input int l, input int pa, input int pc);
      memPoke(8'd0,  8'(m));
      memPoke(8'd2,  8'(n));
      memPoke(8'd4,  8'(l));
      memPoke(8'd12, 8'(pa));
      memPoke(8'd14, 8'(pc));
   endtask

   task automatic loadTest1();
      loadDims(2, 3, 2, 15, 70);
      for (int q = 0; q < 12; q++) memPoke(8'(15 + q), 8'(q + 1));
   endtask

   // Four 16-bit C elements stored little-endian at base, base+2, ...
   task automatic checkC(input string tag, input logic [7:0] base, input int e0, input int e1,
                         input int e2, input int e3);
      int exp4 [4];
      logic [7:0] a;
      exp4 = '{e0, e1, e2, e3};
      for (int q = 0; q < 4; q++) begin
         a = base + 8'(2 * q);
         checkOutput($sformatf("%s_c%0d_lo", tag, q), int'(mem[a]), exp4[q] & 255);
         a = a + 8'd1;
         checkOutput($sformatf("%s_c%0d_hi", tag, q), int'(mem[a]), exp4[q] >> 8);
      end
   endtask

   // Pulses start, then counts edges until done (bounded); optionally re-pulses start mid-job.
   task automatic applyStimulus(input int midStart, input int limit);
      cycles = 0;
      wes    = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("busy_after_accept", int'(busy), 1);
      while (!done && cycles < limit) begin
         @(posedge clk);
         #1;
         cycles++;
         if (mem_we) wes++;
         start = (cycles == midStart);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b1;
      start  = 1'b0;
      tbWe   = 1'b0;
      tbAddr = '0;
      tbData = '0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_busy",   int'(busy), 0);
      checkOutput("rst_done",   int'(done), 0);
      checkOutput("rst_we",     int'(mem_we), 0);
      checkOutput("rst_r_addr", int'(mem_r_addr), 0);
      checkOutput("rst_w_addr", int'(mem_w_addr), 0);
      checkOutput("rst_w_data", int'(mem_w_data), 0);

      // Test 1: 2x3 times 3x2
      loadTest1();
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(-1, 200);
      checkOutput("t1_cycles", cycles, 46);
      checkOutput("t1_we_pulses", wes, 4);
      checkOutput("t1_done", int'(done), 1);
      checkOutput("t1_busy_in_done", int'(busy), 0);
      checkC("t1", 8'd70, 58, 64, 139, 154);

      // Test 2: zero dimension
      memPoke(8'd0, 8'd0);
      applyStimulus(-1, 100);
      checkOutput("t2_cycles", cycles, 6);
      checkOutput("t2_we_pulses", wes, 0);
      @(posedge clk);
      #1;
      checkOutput("t2_busy_after", int'(busy), 0);
      checkOutput("t2_done_after", int'(done), 0);

      // Test 3: 1x1x1, 255*255
      loadDims(1, 1, 1, 15, 70);
      memPoke(8'd15, 8'd255);
      memPoke(8'd16, 8'd255);
      applyStimulus(-1, 100);
      checkOutput("t3_cycles", cycles, 10);
      checkOutput("t3_lo", int'(mem[70]), 8'h01);
      checkOutput("t3_hi", int'(mem[71]), 8'hFE);

      // Test 4: accumulator wrap
      loadDims(1, 3, 1, 15, 70);
      for (int q = 0; q < 6; q++) memPoke(8'(15 + q), 8'd200);
      applyStimulus(-1, 100);
      checkOutput("t4_cycles", cycles, 16);
      checkOutput("t4_lo", int'(mem[70]), 8'hC0);
      checkOutput("t4_hi", int'(mem[71]), 8'hD4);

      // Test 5: reset after the second write, then rerun
      loadTest1();
      for (int q = 0; q < 8; q++) memPoke(8'(70 + q), 8'hAA);
      cycles = 0;
      wes    = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (wes < 2 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (mem_we) wes++;
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_busy",   int'(busy), 0);
      checkOutput("t5_rst_done",   int'(done), 0);
      checkOutput("t5_rst_we",     int'(mem_we), 0);
      checkOutput("t5_rst_r_addr", int'(mem_r_addr), 0);
      checkOutput("t5_rst_w_addr", int'(mem_w_addr), 0);
      checkC("t5_partial", 8'd70, 58, 64, 16'hAAAA, 16'hAAAA);
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(-1, 200);
      checkOutput("t5_cycles", cycles, 46);
      checkOutput("t5_we_pulses", wes, 4);
      checkC("t5_rerun", 8'd70, 58, 64, 139, 154);

      // Test 6: start while busy is ignored; C wraps from 254
      memPoke(8'd14, 8'd254);
      applyStimulus(10, 200);
      checkOutput("t6_cycles", cycles, 46);
      checkOutput("t6_we_pulses", wes, 4);
      checkC("t6", 8'd254, 58, 64, 139, 154);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t6_no_requeue_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
